// File: rtl/grf_writeback.sv
// MIPS writeback stage with the 32x32 general register file, same-cycle W->D bypass,
// a per-cycle writeback trace and a retired-instruction counter.
module grf_writeback #(
  parameter logic [31:0] PC_LINK_OFFSET = 32'd8,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteEnableW,
  input  logic             MemtoRegW,
  input  logic             jalselW,
  input  logic [31:0]      PcW,
  input  logic [31:0]      ALUOutW,
  input  logic [31:0]      ReadDataW,
  input  logic [2:0]       LoadTypeW,
  input  logic [3:0]       MDUOpW,
  input  logic [31:0]      MDUOutW,
  input  logic [4:0]       A3W,
  input  logic             ValidW,
  input  logic [4:0]       A1D,
  input  logic [4:0]       A2D,
  output logic [31:0]      RD1D,
  output logic [31:0]      RD2D,
  output logic             wb_we,
  output logic [31:0]      wb_pc,
  output logic [4:0]       wb_addr,
  output logic [31:0]      wb_data,
  output logic [CNT_W-1:0] retire_cnt
);

  logic [31:0]      grf_q [0:31];
  logic [CNT_W-1:0] retire_cnt_q;
  logic [CNT_W-1:0] retire_cnt_d;
  logic [7:0]       byte_s;
  logic [15:0]      half_s;
  logic [31:0]      load_ext_s;
  logic [31:0]      wd_s;
  logic             we_s;

  // Byte/halfword selection by the low address bits; off[0] is ignored for halfwords.
  always_comb begin
    byte_s = 8'h00;
    case (ALUOutW[1:0])
      2'd0:    byte_s = ReadDataW[7:0];
      2'd1:    byte_s = ReadDataW[15:8];
      2'd2:    byte_s = ReadDataW[23:16];
      2'd3:    byte_s = ReadDataW[31:24];
      default: byte_s = 8'h00;
    endcase
    if (ALUOutW[1]) begin
      half_s = ReadDataW[31:16];
    end else begin
      half_s = ReadDataW[15:0];
    end
  end

  always_comb begin
    load_ext_s = ReadDataW;
    case (LoadTypeW)
      3'd1:    load_ext_s = {{24{byte_s[7]}}, byte_s};
      3'd2:    load_ext_s = {24'h000000, byte_s};
      3'd3:    load_ext_s = {{16{half_s[15]}}, half_s};
      3'd4:    load_ext_s = {16'h0000, half_s};
      default: load_ext_s = ReadDataW;
    endcase
  end

  always_comb begin
    wd_s = ALUOutW;
    if (jalselW) begin
      wd_s = PcW + PC_LINK_OFFSET;
    end else if (MemtoRegW) begin
      wd_s = load_ext_s;
    end else if ((MDUOpW == 4'd5) || (MDUOpW == 4'd6)) begin
      wd_s = MDUOutW;
    end else begin
      wd_s = ALUOutW;
    end
  end

  assign we_s = RegWriteEnableW & ValidW & (A3W != 5'd0);

  // Read ports: $0 is hard zero, a matching write in flight wins over stored contents.
  always_comb begin
    RD1D = 32'h0000_0000;
    RD2D = 32'h0000_0000;
    if (A1D == 5'd0) begin
      RD1D = 32'h0000_0000;
    end else if (we_s && (A1D == A3W)) begin
      RD1D = wd_s;
    end else begin
      RD1D = grf_q[A1D];
    end
    if (A2D == 5'd0) begin
      RD2D = 32'h0000_0000;
    end else if (we_s && (A2D == A3W)) begin
      RD2D = wd_s;
    end else begin
      RD2D = grf_q[A2D];
    end
  end

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (ValidW) begin
      retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retire_cnt_d = retire_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        grf_q[i] <= 32'h0000_0000;
      end
      retire_cnt_q <= {CNT_W{1'b0}};
    end else begin
      if (we_s) begin
        grf_q[A3W] <= wd_s;
      end
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign wb_we      = we_s;
  assign wb_pc      = PcW;
  assign wb_addr    = A3W;
  assign wb_data    = wd_s;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_grf_writeback.sv
// Directed self-checking bench for grf_writeback: write/read, $0, bypass, load
// extension, write-data priority, bubbles and asynchronous reset.
module tb_grf_writeback;

  logic        clk;
  logic        reset;
  logic        RegWriteEnableW;
  logic        MemtoRegW;
  logic        jalselW;
  logic [31:0] PcW;
  logic [31:0] ALUOutW;
  logic [31:0] ReadDataW;
  logic [2:0]  LoadTypeW;
  logic [3:0]  MDUOpW;
  logic [31:0] MDUOutW;
  logic [4:0]  A3W;
  logic        ValidW;
  logic [4:0]  A1D;
  logic [4:0]  A2D;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic        wb_we;
  logic [31:0] wb_pc;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] retire_cnt;

  int n_cmp = 0;
  int n_err = 0;

  grf_writeback #(.PC_LINK_OFFSET(32'd8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .RegWriteEnableW(RegWriteEnableW), .MemtoRegW(MemtoRegW),
    .jalselW(jalselW), .PcW(PcW), .ALUOutW(ALUOutW), .ReadDataW(ReadDataW),
    .LoadTypeW(LoadTypeW), .MDUOpW(MDUOpW), .MDUOutW(MDUOutW), .A3W(A3W),
    .ValidW(ValidW), .A1D(A1D), .A2D(A2D), .RD1D(RD1D), .RD2D(RD2D),
    .wb_we(wb_we), .wb_pc(wb_pc), .wb_addr(wb_addr), .wb_data(wb_data),
    .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  ld_type [5];
  logic [1:0]  ld_off  [5];
  logic [31:0] ld_exp  [5];

  initial begin
    ld_type[0] = 3'd1; ld_off[0] = 2'd3; ld_exp[0] = 32'hFFFF_FF80;
    ld_type[1] = 3'd2; ld_off[1] = 2'd1; ld_exp[1] = 32'h0000_007F;
    ld_type[2] = 3'd3; ld_off[2] = 2'd2; ld_exp[2] = 32'hFFFF_80FF;
    ld_type[3] = 3'd4; ld_off[3] = 2'd0; ld_exp[3] = 32'h0000_7F01;
    ld_type[4] = 3'd5; ld_off[4] = 2'd2; ld_exp[4] = 32'h80FF_7F01;

    reset = 1'b0; RegWriteEnableW = 1'b0; MemtoRegW = 1'b0; jalselW = 1'b0;
    PcW = 32'h0; ALUOutW = 32'h0; ReadDataW = 32'h0; LoadTypeW = 3'd0;
    MDUOpW = 4'd0; MDUOutW = 32'h0; A3W = 5'd0; ValidW = 1'b0; A1D = 5'd0; A2D = 5'd0;

    // Reset held for two cycles
    edge_step();
    edge_step();
    A1D = 5'd5; A2D = 5'd31;
    #1;
    check("rst_cnt", retire_cnt, 32'd0);
    check("rst_rd1", RD1D, 32'h0);
    check("rst_rd2", RD2D, 32'h0);

    // Release and write $5
    reset = 1'b1;
    ValidW = 1'b1; RegWriteEnableW = 1'b1; A3W = 5'd5; ALUOutW = 32'h1234_5678; PcW = 32'h0000_1000;
    #1;
    check("wr_we", {31'd0, wb_we}, 32'd1);
    check("wr_pc", wb_pc, 32'h0000_1000);
    check("wr_addr", {27'd0, wb_addr}, 32'd5);
    check("wr_data", wb_data, 32'h1234_5678);
    edge_step();
    ValidW = 1'b0;
    #1;
    check("wr_rd1", RD1D, 32'h1234_5678);
    check("wr_cnt", retire_cnt, 32'd1);

    // $0 protection
    ValidW = 1'b1; A3W = 5'd0; ALUOutW = 32'hFFFF_FFFF; A1D = 5'd0; A2D = 5'd0;
    #1;
    check("z_we", {31'd0, wb_we}, 32'd0);
    check("z_data", wb_data, 32'hFFFF_FFFF);
    check("z_rd1", RD1D, 32'h0);
    edge_step();
    ValidW = 1'b0;
    #1;
    check("z_rd2", RD2D, 32'h0);
    check("z_cnt", retire_cnt, 32'd2);

    // Same-cycle bypass on both ports
    ValidW = 1'b1; A3W = 5'd8; ALUOutW = 32'hDEAD_BEEF; A1D = 5'd8; A2D = 5'd8;
    #1;
    check("byp_rd1", RD1D, 32'hDEAD_BEEF);
    check("byp_rd2", RD2D, 32'hDEAD_BEEF);
    edge_step();
    ValidW = 1'b0; A1D = 5'd8; A2D = 5'd5;
    #1;
    check("byp_st1", RD1D, 32'hDEAD_BEEF);
    check("byp_st2", RD2D, 32'h1234_5678);

    // Load extension, each written to $10..$14
    MemtoRegW = 1'b1; ReadDataW = 32'h80FF_7F01;
    for (int k = 0; k < 5; k++) begin
      ValidW = 1'b1; LoadTypeW = ld_type[k]; ALUOutW = {30'd0, ld_off[k]};
      A3W = 5'd10 + 5'(k);
      #1;
      check($sformatf("ld%0d_wd", k), wb_data, ld_exp[k]);
      edge_step();
      ValidW = 1'b0; A2D = 5'd10 + 5'(k);
      #1;
      check($sformatf("ld%0d_rf", k), RD2D, ld_exp[k]);
    end
    check("ld_cnt", retire_cnt, 32'd8);

    // jal wins over load
    ValidW = 1'b1; jalselW = 1'b1; MemtoRegW = 1'b1; PcW = 32'h0000_3000; A3W = 5'd31;
    #1;
    check("jal_wd", wb_data, 32'h0000_3008);
    edge_step();
    ValidW = 1'b0; A1D = 5'd31;
    #1;
    check("jal_rf", RD1D, 32'h0000_3008);
    check("jal_cnt", retire_cnt, 32'd9);

    // MDU select vs ALU fallback
    jalselW = 1'b0; MemtoRegW = 1'b0; MDUOpW = 4'd5; MDUOutW = 32'd7; ALUOutW = 32'h0000_AAAA;
    #1;
    check("mfhi_wd", wb_data, 32'd7);
    MDUOpW = 4'd6;
    #1;
    check("mflo_wd", wb_data, 32'd7);
    MDUOpW = 4'd4;
    #1;
    check("alu_wd", wb_data, 32'h0000_AAAA);
    MDUOpW = 4'd0;

    // Bubble with write request
    ValidW = 1'b0; RegWriteEnableW = 1'b1; A3W = 5'd5; ALUOutW = 32'h0000_0BAD; A1D = 5'd5;
    #1;
    check("bub_we", {31'd0, wb_we}, 32'd0);
    check("bub_rd1", RD1D, 32'h1234_5678);
    edge_step();
    check("bub_rf", RD1D, 32'h1234_5678);
    check("bub_cnt", retire_cnt, 32'd9);

    // Asynchronous reset between edges
    A2D = 5'd31;
    #2;
    reset = 1'b0;
    #1;
    check("ar_rd1", RD1D, 32'h0);
    check("ar_rd2", RD2D, 32'h0);
    check("ar_cnt", retire_cnt, 32'd0);

    // Write attempted across an edge while reset is low is discarded
    ValidW = 1'b1; A3W = 5'd20; ALUOutW = 32'h5555_5555;
    edge_step();
    ValidW = 1'b0; reset = 1'b1; A1D = 5'd20; A2D = 5'd8;
    #1;
    check("ar_disc", RD1D, 32'h0);
    check("ar_rd8", RD2D, 32'h0);
    check("ar_cnt2", retire_cnt, 32'd0);

    // First edge after release writes
    ValidW = 1'b1; A3W = 5'd20; ALUOutW = 32'h0000_0042;
    edge_step();
    ValidW = 1'b0;
    #1;
    check("rel_rf", RD1D, 32'h0000_0042);
    check("rel_cnt", retire_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/grf_writeback.md
Name: grf_writeback

Overview:
- Writeback stage plus general register file (GRF) for the 5-stage MIPS pipeline.
- Consumes the W-stage pipeline register outputs, forms the final write value, writes the 32x32 GRF, and serves the two D-stage read ports with internal W→D bypass.
- Also exposes a per-cycle writeback trace and a retired-instruction counter for the bench.

Parameters:
- PC_LINK_OFFSET, 32'd8, value added to PcW for jal/jalr link data.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- RegWriteEnableW  in  1  GRF write request from W register.
- MemtoRegW  in  1  select load data.
- jalselW  in  1  select link address.
- PcW  in  32  PC of W-stage instruction.
- ALUOutW  in  32  ALU result; [1:0] is the load byte offset.
- ReadDataW  in  32  raw DM word.
- LoadTypeW  in  3  0=lw, 1=lb, 2=lbu, 3=lh, 4=lhu; 5-7 treated as lw.
- MDUOpW  in  4  MDU op; 4'd5=mfhi and 4'd6=mflo select MDUOutW.
- MDUOutW  in  32  HI/LO read value.
- A3W  in  5  destination register.
- ValidW  in  1  W slot holds a real (non-bubble) instruction.
- A1D  in  5  D-stage read address 1.
- A2D  in  5  D-stage read address 2.
- RD1D  out  32  read data 1.
- RD2D  out  32  read data 2.
- wb_we  out  1  trace: write performed this cycle.
- wb_pc  out  32  trace: PcW.
- wb_addr  out  5  trace: A3W.
- wb_data  out  32  trace: WD.
- retire_cnt  out  CNT_W  count of retired valid instructions.

Behaviour:
- Write data WD (combinational), priority highest first:
  1. jalselW → PcW + PC_LINK_OFFSET (mod 2^32).
  2. MemtoRegW → extended load data.
  3. MDUOpW ∈ {5,6} → MDUOutW.
  4. else → ALUOutW.
- Load extension uses off = ALUOutW[1:0]; byte = ReadDataW[8*off+7 : 8*off].
  - lb: sign-extend byte. lbu: zero-extend byte.
  - lh/lhu: half = off[1] ? [31:16] : [15:0]; sign-/zero-extend; off[0] ignored.
  - lw: ReadDataW unchanged.
- Write enable we = RegWriteEnableW & ValidW & (A3W != 0).
  - On the rising clk edge with we=1, GRF[A3W] <= WD.
  - Register 0 is never written and always reads 0.
- Reads are combinational.
  - RDxD = 0 if AxD==0.
  - else WD if we and AxD==A3W (same-cycle bypass, write-before-read).
  - else GRF[AxD].
  - Both ports may bypass simultaneously when A1D==A2D==A3W.
- Trace outputs are combinational in the same cycle: wb_we=we, wb_pc=PcW, wb_addr=A3W, wb_data=WD. They are driven even when wb_we=0.
- retire_cnt increments by 1 on each rising edge with ValidW=1, whether or not a register is written. It wraps modulo 2^CNT_W.
- Reset (reset==0), asynchronous, takes effect immediately regardless of clk:
  - GRF[1..31]=0 and retire_cnt=0.
  - RD1D/RD2D therefore read 0 unless a bypass is active; writes are blocked while reset is low.
  - Release is synchronous to the next clk edge; the first edge with reset==1 may write.
- Reset asserted mid-operation discards any write on that edge; no partial state persists.
- Single-cycle stage: latency from W inputs to GRF update is 1 edge; bypass latency is 0.

Test Plan:
- Reset then write: reset low 2 cycles then high; ValidW=1, RegWriteEnableW=1, A3W=5, ALUOutW=32'h1234_5678 → after edge, A1D=5 reads 32'h1234_5678; retire_cnt=1.
- $0 protection: A3W=0, ALUOutW=32'hFFFF_FFFF, write enabled → wb_we=0; A1D=0 reads 0.
- Bypass: in the same cycle A3W=8, WD=32'hDEAD_BEEF, A1D=A2D=8 → RD1D=RD2D=32'hDEAD_BEEF before the edge.
- Load extension: ReadDataW=32'h80FF_7F01.
  - lb off=3 → 32'hFFFF_FF80.
  - lbu off=1 → 32'h0000_007F.
  - lh off=2 → 32'hFFFF_80FF.
  - lhu off=0 → 32'h0000_7F01.
- Priority: jalselW=1, MemtoRegW=1, PcW=32'h0000_3000, A3W=31 → GRF[31]=32'h0000_3008. Then MDUOpW=5, MDUOutW=7 → WD=7.
- Bubble and async reset: ValidW=0 with write request → no write, retire_cnt unchanged. Pulse reset low between edges → all registers 0 immediately, retire_cnt=0.
